// File: rtl/minmax_datapath.sv
// Sample pipeline plus running min/max registers for the min/max tracking controller.
// Provides forwarded comparator flags, a saturating sample count and a registered range.
module minmax_datapath #(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     data_in,
    input  logic             reg_clr,
    input  logic             reg_ld,
    input  logic             max_clr,
    input  logic             max_ld,
    input  logic             min_clr,
    input  logic             min_ld,
    output logic             A_lt_B,
    output logic             C_gt_D,
    output logic [W-1:0]     min_out,
    output logic [W-1:0]     max_out,
    output logic [W-1:0]     range_out,
    output logic             range_valid,
    output logic [CNT_W-1:0] sample_cnt
);

    localparam logic [W-1:0]     ALL_ONES = {W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [W-1:0]     r_data_reg;
    logic [W-1:0]     r_data_d;
    logic [W-1:0]     r_min;
    logic [W-1:0]     r_max;
    logic [W-1:0]     r_range;
    logic             r_range_valid;
    logic [CNT_W-1:0] r_cnt;

    logic [W-1:0]     w_eff_min;
    logic [W-1:0]     w_eff_max;
    logic             w_bound_clr;

    // Forward this cycle's clear/load so back-to-back decisions see the new bound.
    always_comb begin
        w_eff_min = r_min;
        if (min_clr)
            w_eff_min = ALL_ONES;
        else if (min_ld)
            w_eff_min = r_data_d;

        w_eff_max = r_max;
        if (max_clr)
            w_eff_max = '0;
        else if (max_ld)
            w_eff_max = r_data_d;
    end

    assign w_bound_clr = min_clr | max_clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_reg    <= '0;
            r_data_d      <= '0;
            r_min         <= ALL_ONES;
            r_max         <= '0;
            r_cnt         <= '0;
            r_range       <= '0;
            r_range_valid <= 1'b0;
        end else begin
            if (reg_clr) begin
                r_data_reg <= '0;
                r_data_d   <= '0;
            end else if (reg_ld) begin
                r_data_reg <= data_in;
                r_data_d   <= r_data_reg;
            end

            r_min <= w_eff_min;
            r_max <= w_eff_max;

            if (w_bound_clr)
                r_cnt <= '0;
            else if (reg_ld && (r_cnt != CNT_MAX))
                r_cnt <= r_cnt + 1'b1;

            if (w_bound_clr) begin
                r_range       <= '0;
                r_range_valid <= 1'b0;
            end else begin
                r_range       <= w_eff_max - w_eff_min;
                r_range_valid <= (w_eff_max >= w_eff_min) && (r_cnt != '0);
            end
        end
    end

    assign A_lt_B      = (r_data_reg < w_eff_min);
    assign C_gt_D      = (r_data_reg > w_eff_max);
    assign min_out     = r_min;
    assign max_out     = r_max;
    assign range_out   = r_range;
    assign range_valid = r_range_valid;
    assign sample_cnt  = r_cnt;

endmodule

// File: tb/tb_minmax_datapath.sv
// Directed bench for minmax_datapath: reset, pipeline, forwarding, range, priority, saturation.
module tb_minmax_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data_in;
    logic        reg_clr, reg_ld, max_clr, max_ld, min_clr, min_ld;
    logic        A_lt_B, C_gt_D, range_valid;
    logic [7:0]  min_out, max_out, range_out;
    logic [15:0] sample_cnt;

    logic        s_A_lt_B, s_C_gt_D, s_range_valid;
    logic [7:0]  s_min_out, s_max_out, s_range_out;
    logic [3:0]  s_sample_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    minmax_datapath #(.W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .data_in(data_in),
        .reg_clr(reg_clr), .reg_ld(reg_ld),
        .max_clr(max_clr), .max_ld(max_ld),
        .min_clr(min_clr), .min_ld(min_ld),
        .A_lt_B(A_lt_B), .C_gt_D(C_gt_D),
        .min_out(min_out), .max_out(max_out),
        .range_out(range_out), .range_valid(range_valid),
        .sample_cnt(sample_cnt)
    );

    // Narrow counter copy sharing the same stimulus, used for saturation.
    minmax_datapath #(.W(8), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .data_in(data_in),
        .reg_clr(reg_clr), .reg_ld(reg_ld),
        .max_clr(max_clr), .max_ld(max_ld),
        .min_clr(min_clr), .min_ld(min_ld),
        .A_lt_B(s_A_lt_B), .C_gt_D(s_C_gt_D),
        .min_out(s_min_out), .max_out(s_max_out),
        .range_out(s_range_out), .range_valid(s_range_valid),
        .sample_cnt(s_sample_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reg_clr = 0; reg_ld = 0; max_clr = 0; max_ld = 0; min_clr = 0; min_ld = 0;
    endtask

    initial begin
        rst = 1; data_in = 8'd0; idle();
        // reset with random strobes
        for (int i = 0; i < 2; i++) begin
            {reg_clr, reg_ld, max_clr, max_ld, min_clr, min_ld} = 6'($urandom);
            data_in = 8'($urandom);
            tick();
        end
        check("rst_min", 32'(min_out), 32'hFF);
        check("rst_max", 32'(max_out), 0);
        check("rst_cnt", 32'(sample_cnt), 0);
        check("rst_rv", 32'(range_valid), 0);
        check("rst_range", 32'(range_out), 0);
        rst = 0; idle(); #1;
        check("rst_A_lt_B", 32'(A_lt_B), 1);
        check("rst_C_gt_D_eq", 32'(C_gt_D), 0);

        // pipeline 10, 20
        reg_ld = 1; data_in = 8'd10; tick();
        data_in = 8'd20; tick();
        reg_ld = 0; #1;
        check("pipe_data_reg", 32'(dut.r_data_reg), 20);
        check("pipe_data_d", 32'(dut.r_data_d), 10);
        check("pipe_cnt", 32'(sample_cnt), 2);
        check("pipe_rv", 32'(range_valid), 0);
        check("pipe_A", 32'(A_lt_B), 1);
        check("pipe_C", 32'(C_gt_D), 1);

        min_ld = 1; #1;
        check("fwd_min_A", 32'(A_lt_B), 0);
        tick(); min_ld = 0;
        check("load_min", 32'(min_out), 10);

        max_ld = 1; #1;
        check("fwd_max_C", 32'(C_gt_D), 1);
        tick(); max_ld = 0;
        check("load_max", 32'(max_out), 10);
        check("eq_range", 32'(range_out), 0);
        check("eq_rv", 32'(range_valid), 1);

        // forwarding: min_reg=50, data_d=30, data_reg=40
        reg_ld = 1; data_in = 8'd50; tick(); tick();
        reg_ld = 0; min_ld = 1; tick(); min_ld = 0;
        check("min50", 32'(min_out), 50);
        reg_ld = 1; data_in = 8'd30; tick();
        data_in = 8'd40; tick();
        reg_ld = 0; #1;
        check("fwd_noload_A", 32'(A_lt_B), 1);
        min_ld = 1; max_ld = 1; #1;
        check("fwd_load_A", 32'(A_lt_B), 0);
        check("fwd_load_C", 32'(C_gt_D), 1);
        tick(); idle();
        check("dual_min", 32'(min_out), 30);
        check("dual_max", 32'(max_out), 30);
        check("dual_cnt", 32'(sample_cnt), 6);

        // range: max 200, min 30
        reg_ld = 1; data_in = 8'd200; tick();
        data_in = 8'd0; tick();
        reg_ld = 0; max_ld = 1; tick(); max_ld = 0;
        check("max200", 32'(max_out), 200);
        tick();
        check("range170", 32'(range_out), 170);
        check("range_rv", 32'(range_valid), 1);
        check("range_cnt", 32'(sample_cnt), 8);
        check("range_A", 32'(A_lt_B), 1);
        check("range_C", 32'(C_gt_D), 0);

        max_clr = 1; #1;
        check("clr_fwd_C", 32'(C_gt_D), 0);
        tick(); max_clr = 0;
        check("clr_max", 32'(max_out), 0);
        check("clr_cnt", 32'(sample_cnt), 0);
        check("clr_rv", 32'(range_valid), 0);
        check("clr_range", 32'(range_out), 0);
        tick();
        check("cnt0_rv", 32'(range_valid), 0);
        check("cnt0_range", 32'(range_out), 226);

        // A_lt_B equality: data_reg 30 vs min 30
        reg_ld = 1; data_in = 8'd30; tick();
        reg_ld = 0; #1;
        check("eq_A", 32'(A_lt_B), 0);
        check("eq_cnt", 32'(sample_cnt), 1);

        // priority
        min_clr = 1; min_ld = 1; #1;
        check("prio_fwd_A", 32'(A_lt_B), 1);
        tick(); idle();
        check("prio_min", 32'(min_out), 8'hFF);
        check("prio_cnt", 32'(sample_cnt), 0);
        reg_clr = 1; reg_ld = 1; data_in = 8'd99; tick(); idle();
        check("prio_data_reg", 32'(dut.r_data_reg), 0);
        check("prio_reg_cnt", 32'(sample_cnt), 1);
        min_ld = 1; tick(); idle();
        check("prio_data_d", 32'(min_out), 0);

        // mid-stream reset
        reg_ld = 1; data_in = 8'd55; max_ld = 1; tick();
        rst = 1; tick();
        rst = 0; idle(); #1;
        check("mrst_max", 32'(max_out), 0);
        check("mrst_min", 32'(min_out), 8'hFF);
        check("mrst_cnt", 32'(sample_cnt), 0);
        check("mrst_rv", 32'(range_valid), 0);
        check("mrst_data_reg", 32'(dut.r_data_reg), 0);

        // saturation
        reg_ld = 1; data_in = 8'd1;
        for (int i = 0; i < 14; i++) tick();
        check("sat14", 32'(s_sample_cnt), 14);
        tick();
        check("sat15", 32'(s_sample_cnt), 15);
        for (int i = 0; i < 5; i++) tick();
        idle(); #1;
        check("sat_hold", 32'(s_sample_cnt), 15);
        check("wide_cnt20", 32'(sample_cnt), 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
